red_pitaya_pwm_meas: RTL and testbench
======================================

Name: red_pitaya_pwm_meas

Overview:
- Receive-side counterpart of the PWM/RC DAC: measures duty cycle of a 1-bit PWM input (external pin or loopback of a PWM output).
- Samples at the same prescaled tick rate the PWM generator uses.
- Accumulates high-ticks over a 16-frame metacycle, reconstructing the 8-bit value plus its dithered fractional bits as one 13-bit result.
- Also reports rising-edge count per window, to flag stuck-at and DC inputs.

Parameters:
- DIV_W, 4: prescaler width; one sample tick every 2^DIV_W clk cycles.
- FULL, 8'd255: last tick index of a frame; a frame is FULL+1 ticks.
- NFR_LOG, 4: log2 of frames per measurement window (NFR = 16).
- OW, 13: result width; must satisfy 2^OW > NFR*(FULL+1).

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous, active-low
- pwm_i  input  1  PWM input, asynchronous to clk
- en_i  input  1  measurement enable
- mode_i  input  1  0 = free-running windows; 1 = each window starts on sync_i
- sync_i  input  1  1-clk start pulse; connect to the generator's metacycle sync
- meas_o  output  OW  high-tick count of last completed window
- edges_o  output  8  rising edges in last completed window, saturating at 255
- valid_o  output  1  1-clk pulse when meas_o/edges_o update
- busy_o  output  1  high while a window is in progress (state MEAS)

Behaviour:
- Reset (async, rstn=0): meas_o=0, edges_o=0, valid_o=0, busy_o=0, state IDLE, all counters 0, synchronizer flops 0.
- Input path: 2-flop synchronizer pwm_i -> p1 -> p2; p2 lags pwm_i by 2 clk. Rising edge is p2 & ~p3, with p3 one more delay flop.
- Prescaler div (DIV_W bits) runs only in MEAS. tick = (div == all ones).
- States:
  - IDLE: en_i=0. Counters held at 0. Go to ARM when en_i=1.
  - ARM: mode_i=0 -> MEAS next cycle. mode_i=1 -> wait for sync_i=1, then MEAS next cycle.
  - MEAS: counters cleared on entry cycle S. On each tick: hcnt += p2; tcnt++. At tcnt==FULL, tcnt wraps to 0 and fcnt++. ecnt += rise every clk, saturating at 255.
  - Completion: the tick with tcnt==FULL and fcnt==NFR-1.
    - Next cycle: meas_o <= final hcnt (including this tick's sample), edges_o <= final ecnt, valid_o=1 for 1 clk.
    - Window length is exactly NFR*(FULL+1)*2^DIV_W clk (65536 default) from S to valid_o.
    - After completion: mode_i=0 -> new window starts immediately, all counters 0, so valid_o period is exactly 65536 clk. mode_i=1 -> ARM.
- Boundaries and overrides:
  - en_i=0 in any state -> IDLE next cycle. Partial window discarded, no valid_o, meas_o/edges_o hold previous values.
  - sync_i during MEAS with mode_i=1 -> restart: counters cleared, new S, no valid_o for the aborted window.
  - sync_i in the same cycle as the completion tick -> completion wins: valid_o issued normally, then the next window starts directly (ARM skipped).
  - mode_i is sampled only in ARM and at completion. Changes mid-window take effect at the next window.
- Range: hcnt is OW bits, range 0..NFR*(FULL+1) = 0..4096, no overflow at default parameters.
- Steady-state property: for a periodic input with period equal to one window, meas_o is independent of window phase.
- busy_o = (state==MEAS), registered.

Test Plan:
- pwm_i=0, en_i=1, mode_i=0 -> valid_o every 65536 clk; meas_o=0, edges_o=0.
- pwm_i=1 held from before en_i rises -> meas_o=4096, edges_o=0.
- Loopback from the PWM generator, cfg=24'h800000, sync_i=its pwm_s, mode_i=1 -> meas_o=2048, edges_o=16. Same with cfg=24'h80FFFF -> meas_o=2064. With cfg=24'h010001 -> meas_o=17, edges_o=16.
- Free-running (mode_i=0), cfg=24'h800000, arbitrary start phase -> meas_o=2048 on every window.
- en_i dropped 30000 clk into a window, re-raised 100 clk later -> no valid_o for the aborted window; next valid_o exactly 65536 clk after re-entering MEAS; meas_o unchanged in between.
- mode_i=1 with second sync_i 1000 clk into a window -> valid_o 65536 clk after the second sync entry, not after the first. sync_i coincident with completion -> valid_o issued and next window starts next cycle.

Source files
------------

// File: rtl/red_pitaya_pwm_meas.sv
// Duty-cycle meter for a 1-bit PWM stream: counts high samples and rising edges
// over an NFR-frame window, sampling at the PWM generator's prescaled tick rate.
module red_pitaya_pwm_meas #(
  parameter int         DIV_W   = 4,
  parameter logic [7:0] FULL    = 8'd255,
  parameter int         NFR_LOG = 4,
  parameter int         OW      = 13
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pwm_i,
  input  logic          en_i,
  input  logic          mode_i,
  input  logic          sync_i,
  output logic [OW-1:0] meas_o,
  output logic [7:0]    edges_o,
  output logic          valid_o,
  output logic          busy_o
);

  // state | meaning
  // IDLE  | disabled, counters held at zero
  // ARM   | enabled, waiting for a window start (immediate or on sync_i)
  // MEAS  | window in progress
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t state, state_nxt;

  logic               p1, p2, p3;
  logic [DIV_W-1:0]   div;
  logic [7:0]         tcnt;
  logic [NFR_LOG-1:0] fcnt;
  logic [OW-1:0]      hcnt;
  logic [7:0]         ecnt;
  logic               mode_q, mode_nxt;
  logic               tick, rise, last, done, start, run;
  logic [OW-1:0]      hcnt_fin;
  logic [7:0]         ecnt_fin;

  assign rise     = p2 & ~p3;
  assign tick     = (state == MEAS) && (&div);
  assign last     = tick && (tcnt == FULL) && (&fcnt);
  assign hcnt_fin = hcnt + OW'(p2);
  assign ecnt_fin = (&ecnt) ? ecnt : ecnt + 8'(rise);
  assign busy_o   = (state == MEAS);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p1 <= 1'b0;
      p2 <= 1'b0;
      p3 <= 1'b0;
    end else begin
      p1 <= pwm_i;
      p2 <= p1;
      p3 <= p2;
    end
  end

  // Completion is checked before the sync restart so a coincident sync never
  // throws away a finished window.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    start     = 1'b0;
    mode_nxt  = mode_q;
    case (state)
      IDLE: begin
        if (en_i) state_nxt = ARM;
      end
      ARM: begin
        if (!en_i) begin
          state_nxt = IDLE;
        end else if (!mode_i || sync_i) begin
          state_nxt = MEAS;
          start     = 1'b1;
          mode_nxt  = mode_i;
        end
      end
      MEAS: begin
        if (!en_i) begin
          state_nxt = IDLE;
        end else if (last) begin
          done     = 1'b1;
          mode_nxt = mode_i;
          if (!mode_i || sync_i) start = 1'b1;
          else state_nxt = ARM;
        end else if (sync_i && mode_q) begin
          start = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign run = (state == MEAS) && (state_nxt == MEAS) && !start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      mode_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      mode_q <= mode_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div  <= '0;
      tcnt <= '0;
      fcnt <= '0;
      hcnt <= '0;
      ecnt <= '0;
    end else if (!run) begin
      div  <= '0;
      tcnt <= '0;
      fcnt <= '0;
      hcnt <= '0;
      ecnt <= '0;
    end else begin
      div  <= div + DIV_W'(1);
      ecnt <= ecnt_fin;
      if (tick) begin
        hcnt <= hcnt_fin;
        if (tcnt == FULL) begin
          tcnt <= '0;
          fcnt <= fcnt + NFR_LOG'(1);
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_o <= 1'b0;
      meas_o  <= '0;
      edges_o <= '0;
    end else begin
      valid_o <= done;
      if (done) begin
        meas_o  <= hcnt_fin;
        edges_o <= ecnt_fin;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pwm_meas.sv
// Bench for red_pitaya_pwm_meas: cycle-accurate window model built from the
// recorded input history, plus literal checks of known duty/edge results.
module tb_red_pitaya_pwm_meas;

  localparam int DIV_W   = 2;
  localparam int NFR_LOG = 3;
  localparam int OW      = 8;
  localparam int P       = 1 << DIV_W;        // clk per tick
  localparam int T       = 16;                // ticks per frame (FULL+1)
  localparam int NS      = T * (1 << NFR_LOG); // samples per window
  localparam int WIN     = NS * P;            // clk per window = 512
  localparam int HB      = 4096;

  logic          clk, rstn, pwm_i, en_i, mode_i, sync_i;
  logic [OW-1:0] meas_o;
  logic [7:0]    edges_o;
  logic          valid_o, busy_o;

  red_pitaya_pwm_meas #(
    .DIV_W(DIV_W), .FULL(8'd15), .NFR_LOG(NFR_LOG), .OW(OW)
  ) dut (
    .clk(clk), .rstn(rstn), .pwm_i(pwm_i), .en_i(en_i), .mode_i(mode_i),
    .sync_i(sync_i), .meas_o(meas_o), .edges_o(edges_o), .valid_o(valid_o),
    .busy_o(busy_o)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  int src = 0, duty = 0, sync_gen = 0, sync_phase = 0, rnd_sync = 0;
  int man_req = 0, man_ack = 0;
  bit ph [HB];
  int mst = 0, win_s = 0, wmode = 0, last_sync = -1;
  int exp_meas = 0, exp_edges = 0, exp_valid = 0, exp_busy = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int p2_at(input int x);
    if (x < 2) return 0;
    return int'(ph[(x - 2) % HB]);
  endfunction

  // Input source: pwm_i and sync_i are owned here, changed on falling edges.
  initial begin
    pwm_i  = 1'b0;
    sync_i = 1'b0;
    forever begin
      @(negedge clk);
      case (src)
        0: pwm_i = 1'b0;
        1: pwm_i = 1'b1;
        2: pwm_i = (((cyc / P) % T) < duty);
        3: pwm_i = ((cyc % 2) == 1);
        4: pwm_i = 1'($urandom_range(0, 1));
        default: if ($urandom_range(0, 19) == 0) pwm_i = ~pwm_i;
      endcase
      sync_i = (sync_gen != 0 && ((cyc + sync_phase) % WIN) == 0) ||
               (rnd_sync != 0 && $urandom_range(0, 299) == 0) ||
               (man_req != man_ack);
      man_ack = man_req;
    end
  end

  // Reference model: window bookkeeping by cycle number, results summed over history.
  initial begin
    forever begin
      @(posedge clk);
      if (rstn) begin
        ph[cyc % HB] = pwm_i;
        exp_valid = 0;
        if (sync_i) last_sync = cyc;
        case (mst)
          0: if (en_i) mst = 1;
          1: begin
            if (!en_i) mst = 0;
            else if (!mode_i || sync_i) begin
              mst = 2; win_s = cyc + 1; wmode = int'(mode_i);
            end
          end
          default: begin
            if (!en_i) mst = 0;
            else if (cyc == win_s + WIN - 1) begin
              int m, e;
              m = 0;
              for (int k = 0; k < NS; k++) m += p2_at(win_s + (k + 1) * P - 1);
              e = 0;
              for (int x = win_s; x <= cyc; x++)
                if (p2_at(x) == 1 && p2_at(x - 1) == 0) e++;
              exp_meas  = m;
              exp_edges = (e > 255) ? 255 : e;
              exp_valid = 1;
              if (!mode_i || sync_i) begin
                win_s = cyc + 1; wmode = int'(mode_i);
              end else mst = 1;
            end else if (sync_i && wmode != 0) win_s = cyc + 1;
          end
        endcase
        exp_busy = (mst == 2) ? 1 : 0;
        cyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        chk("valid", int'(valid_o), exp_valid);
        chk("busy", int'(busy_o), exp_busy);
        chk("meas", int'(meas_o), exp_meas);
        chk("edges", int'(edges_o), exp_edges);
      end
    end
  end

  task automatic wait_valid(input int budget, output int vc);
    vc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (valid_o) begin
        vc = cyc;
        break;
      end
    end
    if (vc < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout at cycle %0d: got no valid_o, expected one within %0d clk", cyc, budget);
    end
  endtask

  initial begin
    int e, v1, v2, v3, vx;
    rstn = 1'b0; en_i = 1'b0; mode_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_meas", int'(meas_o), 0);
    chk("rst_edges", int'(edges_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // constant low, free-running
    en_i = 1'b1; e = cyc;
    wait_valid(700, v1);
    chk("first_latency", v1 - e, 2 + WIN);
    chk("zero_meas", int'(meas_o), 0);
    chk("zero_edges", int'(edges_o), 0);
    wait_valid(700, v2);
    chk("free_period", v2 - v1, WIN);

    // constant high from before enable
    en_i = 1'b0; src = 1;
    repeat (10) @(negedge clk);
    en_i = 1'b1; e = cyc;
    wait_valid(700, v1);
    chk("high_latency", v1 - e, 2 + WIN);
    chk("high_meas", int'(meas_o), NS);
    chk("high_edges", int'(edges_o), 0);

    // duty 5/16, one rising edge per frame
    src = 2; duty = 5;
    repeat (3) wait_valid(700, v1);
    chk("duty5_meas", int'(meas_o), 40);
    chk("duty5_edges", int'(edges_o), 8);

    // toggling every clk: edge count saturates
    src = 3;
    repeat (3) wait_valid(700, v1);
    chk("toggle_edges", int'(edges_o), 255);

    // sync mode, sync coincident with every completion
    src = 2; duty = 8; mode_i = 1'b1; sync_gen = 1;
    sync_phase = $urandom_range(0, WIN - 1);
    repeat (3) wait_valid(1200, v2);
    chk("sync_meas", int'(meas_o), 64);
    chk("sync_edges", int'(edges_o), 8);
    wait_valid(1200, v3);
    chk("sync_period", v3 - v2, WIN);

    // restart by a second sync part-way into a window
    sync_gen = 0;
    repeat (100) @(negedge clk);
    man_req++;
    wait_valid(800, vx);
    chk("restart_latency", vx - last_sync, 1 + WIN);

    // enable dropped mid-window
    mode_i = 1'b0; duty = 3;
    wait_valid(800, v1);
    repeat (300) @(negedge clk);
    en_i = 1'b0;
    repeat (100) @(negedge clk);
    en_i = 1'b1; e = cyc;
    wait_valid(800, vx);
    chk("reenable_latency", vx - e, 2 + WIN);
    chk("duty3_meas", int'(meas_o), 24);
    chk("duty3_edges", int'(edges_o), 8);

    // randomized mix, checked by the model every cycle
    for (int it = 0; it < 40; it++) begin
      src        = $urandom_range(0, 5);
      duty       = $urandom_range(0, 16);
      mode_i     = 1'($urandom_range(0, 1));
      sync_gen   = $urandom_range(0, 1);
      sync_phase = $urandom_range(0, WIN - 1);
      rnd_sync   = $urandom_range(0, 1);
      en_i       = ($urandom_range(0, 7) != 0);
      repeat ($urandom_range(50, 600)) @(negedge clk);
    end

    sync_gen = 0; rnd_sync = 0; en_i = 1'b0;
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
